// File: rtl/float_fixed_seq.sv
// float_fixed_seq: multi-cycle IEEE-754 single-precision to signed Q-format
// fixed-point converter. One operand in flight; mantissa alignment is done by
// a one-bit-per-cycle shifter, so latency depends on the exponent.
module float_fixed_seq #(
    parameter int Q = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] ieee_float,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] fixed_point,
    output logic        ovf
);

    typedef enum logic [1:0] {IDLE, CALC, SHIFT, DONE} state_t;

    // Shift distance is exp - 150 + Q; fold the constant part once.
    localparam logic signed [9:0] SH_BIAS = 10'(150 - Q);

    state_t            state, state_nxt;
    logic              sign_r;
    logic [7:0]        exp_r;
    logic [31:0]       mag_r;
    logic [31:0]       mag_shift;
    logic [4:0]        cnt_r;
    logic              dir_left_r;
    logic signed [9:0] sh;
    logic [4:0]        sh_abs;
    logic              frac_nz;
    logic              calc_go_shift;
    logic [31:0]       calc_fix;
    logic              calc_ovf;

    // Largest representable value of the requested sign.
    function automatic logic [31:0] sat_value(input logic s);
        return s ? 32'h8000_0000 : 32'h7FFF_FFFF;
    endfunction

    // Apply the float's sign to an unsigned magnitude (two's complement).
    function automatic logic [31:0] apply_sign(input logic s, input logic [31:0] m);
        logic signed [31:0] ms;
        ms = $signed(m);
        return s ? 32'(-ms) : m;
    endfunction

    // Classify the registered operand and pick either a final result or a shift.
    always_comb begin
        sh            = $signed({2'b00, exp_r}) - SH_BIAS;
        sh_abs        = sh[9] ? 5'(-sh) : 5'(sh);
        frac_nz       = |mag_r[22:0];
        calc_go_shift = 1'b0;
        calc_fix      = 32'h0000_0000;
        calc_ovf      = 1'b0;
        if (exp_r == 8'hFF && frac_nz) begin
            calc_ovf = 1'b1;
        end else if (exp_r == 8'hFF) begin
            calc_fix = sat_value(sign_r);
            calc_ovf = 1'b1;
        end else if (exp_r == 8'h00) begin
            calc_fix = 32'h0000_0000;
        end else if (sh >= 10'sd8) begin
            calc_fix = sat_value(sign_r);
            calc_ovf = 1'b1;
        end else if (sh <= -10'sd24) begin
            calc_fix = 32'h0000_0000;
        end else if (sh == 10'sd0) begin
            calc_fix = apply_sign(sign_r, mag_r);
        end else begin
            calc_go_shift = 1'b1;
        end
    end

    // One-bit alignment step, direction fixed in CALC.
    always_comb begin
        mag_shift = dir_left_r ? (mag_r << 1) : (mag_r >> 1);
    end

    // State register; reset aborts any conversion in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = CALC;
            CALC:    state_nxt = calc_go_shift ? SHIFT : DONE;
            SHIFT:   if (cnt_r == 5'd1) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs decoded from state.
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // Operand capture and mantissa shifting; fully reloaded on every accept.
    always_ff @(posedge clk) begin
        case (state)
            IDLE: begin
                if (in_valid) begin
                    sign_r <= ieee_float[31];
                    exp_r  <= ieee_float[30:23];
                    mag_r  <= {8'b0, ieee_float[30:23] != 8'h00, ieee_float[22:0]};
                end
            end
            CALC:    dir_left_r <= ~sh[9];
            SHIFT:   mag_r <= mag_shift;
            default: ;
        endcase
    end

    // Shift counter and result registers, loaded on entry to DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r       <= 5'd0;
            fixed_point <= 32'h0000_0000;
            ovf         <= 1'b0;
        end else begin
            case (state)
                CALC: begin
                    if (calc_go_shift) begin
                        cnt_r <= sh_abs;
                    end else begin
                        fixed_point <= calc_fix;
                        ovf         <= calc_ovf;
                    end
                end
                SHIFT: begin
                    cnt_r <= cnt_r - 5'd1;
                    if (cnt_r == 5'd1) begin
                        fixed_point <= apply_sign(sign_r, mag_shift);
                        ovf         <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_float_fixed_seq.sv
// Testbench for float_fixed_seq: directed cases plus randomized operands
// checked against an arithmetic reference model.
module tb_float_fixed_seq;

    localparam int Q = 16;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] ieee_float;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] fixed_point;
    logic        ovf;

    int n_checks = 0;
    int n_err    = 0;

    float_fixed_seq #(.Q(Q)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .ieee_float  (ieee_float),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .fixed_point (fixed_point),
        .ovf         (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Value = (-1)^s * 1.frac * 2^(exp-127), scaled by 2^Q, truncated toward zero.
    function automatic void ref_model(input logic [31:0] f, output logic [31:0] val,
                                      output logic o, output int lat);
        int              ex;
        int              e;
        logic            s;
        longint unsigned m;
        longint unsigned v;
        s   = f[31];
        ex  = int'(f[30:23]);
        lat = 2;
        o   = 1'b0;
        val = 32'h0;
        if (ex == 255) begin
            o   = 1'b1;
            val = (f[22:0] != 0) ? 32'h0 : (s ? 32'h8000_0000 : 32'h7FFF_FFFF);
            return;
        end
        if (ex == 0) return;
        m = 64'h80_0000 + longint'(f[22:0]);
        e = ex - 150 + Q;
        if (e > 40)       v = 64'hFFFF_FFFF_FFFF;
        else if (e >= 0)  v = m << e;
        else if (e < -40) v = 0;
        else              v = m >> (-e);
        if (v >= 64'h8000_0000) begin
            o   = 1'b1;
            val = s ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end else begin
            val = s ? 32'(-v) : 32'(v);
        end
        if (e > 0 && e < 8)        lat = 2 + e;
        else if (e < 0 && e > -24) lat = 2 - e;
    endfunction

    // Convert one operand; optionally hold out_ready low for 'stall' cycles
    // while poking in_valid with a different operand that must be ignored.
    task automatic do_conv(input logic [31:0] f, input int stall);
        logic [31:0] ev;
        logic        eo;
        int          el;
        int          n;
        ref_model(f, ev, eo, el);
        @(negedge clk);
        chk("in_ready_idle", {31'b0, in_ready}, 32'd1);
        in_valid   = 1'b1;
        ieee_float = f;
        out_ready  = (stall == 0);
        @(posedge clk);
        @(negedge clk);
        in_valid   = 1'b0;
        ieee_float = $urandom;
        chk("in_ready_busy", {31'b0, in_ready}, 32'd0);
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        chk("latency", n + 1, el);
        chk("fixed", fixed_point, ev);
        chk("ovf", {31'b0, ovf}, {31'b0, eo});
        for (int i = 0; i < stall; i++) begin
            in_valid   = (i < stall - 1);
            ieee_float = 32'h4000_0000;
            @(posedge clk);
            @(negedge clk);
            chk("hold_valid", {31'b0, out_valid}, 32'd1);
            chk("hold_fixed", fixed_point, ev);
            chk("hold_in_ready", {31'b0, in_ready}, 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("post_valid", {31'b0, out_valid}, 32'd0);
        chk("post_in_ready", {31'b0, in_ready}, 32'd1);
        chk("post_fixed", fixed_point, ev);
        chk("post_ovf", {31'b0, ovf}, {31'b0, eo});
        out_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] f;
        int          r;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        ieee_float = 32'h0;
        out_ready  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_fixed", fixed_point, 32'h0);
        chk("rst_ovf", {31'b0, ovf}, 32'd0);
        rst_n = 1'b1;

        // Directed cases
        do_conv(32'h3F80_0000, 0);   // 1.0
        chk("dir_1p0", fixed_point, 32'h0001_0000);
        do_conv(32'hC020_0000, 0);   // -2.5
        chk("dir_m2p5", fixed_point, 32'hFFFD_8000);
        do_conv(32'h4700_0000, 0);   // 32768.0 saturates
        chk("dir_sat", fixed_point, 32'h7FFF_FFFF);
        do_conv(32'hFF80_0000, 0);   // -Inf
        chk("dir_ninf", fixed_point, 32'h8000_0000);
        do_conv(32'h7FC0_0000, 0);   // NaN
        chk("dir_nan_ovf", {31'b0, ovf}, 32'd1);
        do_conv(32'h3700_0000, 0);   // 2^-17 underflow
        do_conv(32'h0000_0000, 0);
        do_conv(32'h0000_0001, 0);   // denormal
        do_conv(32'h8000_0000, 0);   // -0.0
        do_conv(32'h3F7F_FFFF, 0);   // truncation
        chk("dir_trunc", fixed_point, 32'h0000_FFFF);
        do_conv(32'hC700_0000, 0);   // exactly -2^15 still flags ovf
        chk("dir_min_ovf", {31'b0, ovf}, 32'd1);
        do_conv(32'h4680_0000, 0);   // 16384.0, sh=7 left shifts
        chk("dir_left", fixed_point, 32'h4000_0000);

        // Backpressure with an ignored in_valid pulse
        do_conv(32'h3F80_0000, 6);
        chk("bp_fixed", fixed_point, 32'h0001_0000);

        // Reset during SHIFT of 1.0, after +Inf left nonzero result and ovf
        do_conv(32'h7F80_0000, 0);
        @(negedge clk);
        in_valid   = 1'b1;
        ieee_float = 32'h3F80_0000;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("arst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("arst_fixed", fixed_point, 32'h0);
        chk("arst_ovf", {31'b0, ovf}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_conv(32'hC020_0000, 0);
        chk("after_rst", fixed_point, 32'hFFFD_8000);

        // Randomized operands around the interesting exponent window
        for (int k = 0; k < 200; k++) begin
            f = $urandom;
            r = int'($urandom_range(0, 9));
            if (r == 0)      f[30:23] = 8'hFF;
            else if (r == 1) f[30:23] = 8'h00;
            else             f[30:23] = 8'(150 - Q - 28 + int'($urandom_range(0, 40)));
            if ($urandom_range(0, 5) == 0) f[22:0] = 23'h0;
            do_conv(f, int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/float_fixed_seq.md
# float_fixed_seq

Multi-cycle IEEE-754 single-precision to signed fixed-point converter with Q fractional bits. It sits directly downstream of the FPU arithmetic units and returns their float results to the fixed-point datapath, performing the inverse of the fixed-to-float stage. Mantissa alignment uses an iterative one-bit-per-cycle shifter. Inputs and outputs use valid/ready handshakes; one conversion is in flight at a time.

## Interface
- Q, 16, fractional bits of the fixed-point result; legal range 0..30
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- in_valid  input  1  ieee_float is valid
- in_ready  output  1  block can accept an operand; high only in IDLE
- ieee_float  input  32  operand {sign, exp[7:0], frac[22:0]}
- out_valid  output  1  fixed_point and ovf are valid
- out_ready  input  1  consumer accepts the result
- fixed_point  output  32  two's-complement result with Q fractional bits
- ovf  output  1  result saturated or operand was Inf/NaN

## Operation
- FSM states: IDLE, CALC, SHIFT, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, register sign, exp and mag = {8'b0, exp!=0, frac} (32 bits). Go to CALC.
- CALC: compute sh = exp − 150 + Q (signed, 10 bits minimum). Classify in this priority order:
  - exp==255 with frac!=0 (NaN): result 0x00000000, ovf=1, go to DONE.
  - exp==255 with frac==0 (Inf): saturate, ovf=1, go to DONE.
  - exp==0 (zero or denormal): result 0, ovf=0, go to DONE. Denormals flush to zero.
  - sh ≥ 8: saturate, ovf=1, go to DONE. This includes exactly −2^(31−Q), which still flags ovf.
  - sh ≤ −24: result 0, ovf=0, go to DONE.
  - sh == 0: go to DONE with mag unchanged.
  - Otherwise: load cnt=|sh| (5 bits) and direction, then go to SHIFT.
- Saturation value: 0x7FFFFFFF if sign=0, 0x80000000 if sign=1.
- SHIFT: each cycle, mag shifts one bit (left if sh>0, logical right if sh<0) and cnt decrements. When cnt reaches 1 in SHIFT, the next state is DONE, so SHIFT lasts exactly |sh| cycles.
- Right shifts truncate the magnitude, which rounds toward zero for both signs.
- DONE entry: fixed_point is loaded with mag, or with −mag (two's complement) if sign=1. Special-case and saturation values are loaded unmodified.
- DONE: out_valid=1, and fixed_point/ovf hold stable until out_ready. On out_valid&&out_ready, go to IDLE with out_valid=0 on the next cycle. fixed_point keeps its last value; ovf keeps its last value.
- −0.0 yields 0x00000000.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, fixed_point=0x00000000, ovf=0, cnt=0.
- Reset asserted in any state aborts the conversion immediately. No partial result is ever presented.
- Cycle 0 is the accept edge. out_valid rises after the edge at cycle 1 for special cases, saturation, underflow and sh==0. Otherwise it rises after the edge at cycle 1+|sh|.
- Total latency to out_valid: 2 cycles (special cases) up to 25 cycles (|sh|=23).
- in_ready is 0 from the cycle after acceptance until the cycle after the output handshake.
- Minimum initiation interval is latency + 1 cycle when out_ready is held high.
- in_valid and ieee_float are ignored outside IDLE. ieee_float need not be held after acceptance.
- out_ready is ignored outside DONE.

## Test plan
- Q=16; send 0x3F800000 (1.0), out_ready=1 → fixed_point=0x00010000, ovf=0, out_valid 9 cycles after accept (sh=−7).
- Send 0xC0200000 (−2.5) → fixed_point=0xFFFD8000, ovf=0, latency 8.
- Send 0x47000000 (32768.0) → 0x7FFFFFFF, ovf=1, latency 2. Send 0xFF800000 (−Inf) → 0x80000000, ovf=1. Send 0x7FC00000 (NaN) → 0x00000000, ovf=1.
- Send 0x37000000 (2^−17, sh=−24), then 0x00000000, then 0x00000001 (denormal) → each gives 0x00000000, ovf=0, latency 2. Send 0x3F7FFFFF → 0x0000FFFF (truncation).
- Backpressure: send 1.0 with out_ready=0 for 6 cycles after out_valid → fixed_point stays 0x00010000, out_valid stays 1, in_ready stays 0, and an in_valid pulse with 0x40000000 is not accepted. Raise out_ready → in_ready=1 on the next cycle.
- Drop rst_n during SHIFT of 1.0 → out_valid=0, fixed_point=0, ovf=0, in_ready=1 immediately. Release and convert 0xC0200000 → correct 0xFFFD8000 with no residue from the aborted operation.
